// File: rtl/rr_arbiter_pkg.sv
// ============================================================================
//  Module      : rr_arbiter_pkg
//  Description : Shared types and constants for the round-robin arbiter:
//                FSM state encoding, owner-index width and the helper that
//                sizes the hold-timeout counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rr_arbiter_pkg;

    // Owner index is always carried as an 8-bit MSB-index, matching the
    // encoders that consume gnt_idx downstream.
    localparam int IDX_W = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Width of the hold counter. MAX_HOLD = 0 (timeout disabled) still yields
    // a 1-bit counter so the datapath never has a zero-width vector.
    function automatic int hold_cnt_w(input int max_hold);
        return $clog2(max_hold) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter_if.sv
// ============================================================================
//  Module      : rr_arbiter_if
//  Description : Request/grant bundle between the requesting engines and the
//                arbiter.
//                  req       - request vector, one bit per requester
//                  done      - single-cycle release pulse from the owner
//                  gnt       - registered one-hot grant
//                  gnt_valid - a grant is currently held
//                  gnt_idx   - binary owner index, 0 when no grant
//                  revoked   - one-cycle pulse on timeout revoke
//                Modports: master = requester side, slave = arbiter side.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rr_arbiter_if
    import rr_arbiter_pkg::*;
#(
    parameter int WIDTH_LOG = 2
) ();
    localparam int WIDTH = 1 << WIDTH_LOG;

    logic [WIDTH-1:0] req;
    logic             done;
    logic [WIDTH-1:0] gnt;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_idx;
    logic             revoked;

    modport master (
        output req, done,
        input  gnt, gnt_valid, gnt_idx, revoked
    );

    modport slave (
        input  req, done,
        output gnt, gnt_valid, gnt_idx, revoked
    );

endinterface

`default_nettype wire

// File: rtl/rr_arbiter_pick.sv
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin selector. Requests strictly below
//                the last winner are preferred (MSB first); if none exist the
//                MSB of the full request vector wins.
//                  i_req      - request vector
//                  i_last_idx - index of the previous winner
//                  o_pick_idx - selected index (8-bit, zero-extended)
//                  o_any_req  - at least one request is present
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import rr_arbiter_pkg::*;
#(
    parameter  int WIDTH_LOG = 2,
    localparam int WIDTH     = 1 << WIDTH_LOG
) (
    input  wire logic [WIDTH-1:0] i_req,
    input  wire logic [IDX_W-1:0] i_last_idx,
    output logic      [IDX_W-1:0] o_pick_idx,
    output logic                  o_any_req
);

    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_masked;
    logic [IDX_W-1:0] w_idx_masked;
    logic [IDX_W-1:0] w_idx_all;

    // Two MSB encoders: ascending scan, so the highest set bit is the last
    // one to overwrite the result.
    always_comb begin
        w_mask       = '0;
        w_idx_masked = '0;
        w_idx_all    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_mask[i] = (IDX_W'(i) < i_last_idx);
        end
        w_masked = i_req & w_mask;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_masked[i]) w_idx_masked = IDX_W'(i);
            if (i_req[i])    w_idx_all    = IDX_W'(i);
        end
    end

    assign o_any_req  = |i_req;
    assign o_pick_idx = (|w_masked) ? w_idx_masked : w_idx_all;

endmodule

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter for 2^WIDTH_LOG requesters sharing one
//                unit. A grant is held until done, request drop, or a
//                MAX_HOLD-cycle timeout (MAX_HOLD = 0 disables the timeout).
//                  clk   - clock, all state on posedge
//                  rst_n - synchronous active-low reset
//                  bus   - rr_arbiter_if.slave (req/done in, grant out)
//                Optional macro RR_ARBITER_B2B_EN: hand the grant directly
//                to the next requester on release/timeout with no idle cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int WIDTH_LOG = 2,
    parameter int MAX_HOLD  = 0
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    rr_arbiter_if.slave bus
);

    localparam int WIDTH = 1 << WIDTH_LOG;
    localparam int CNT_W = hold_cnt_w(MAX_HOLD);
    localparam logic [CNT_W-1:0] c_hold_last = (MAX_HOLD != 0) ? CNT_W'(MAX_HOLD - 1) : '0;

`ifdef RR_ARBITER_B2B_EN
    localparam bit c_b2b_en = 1'b1;
`else
    localparam bit c_b2b_en = 1'b0;
`endif

    state_t           r_state_q,    w_state_d;
    logic [WIDTH-1:0] r_gnt_q,      w_gnt_d;
    logic [IDX_W-1:0] r_gnt_idx_q,  w_gnt_idx_d;
    logic [IDX_W-1:0] r_last_idx_q, w_last_idx_d;
    logic [CNT_W-1:0] r_hold_cnt_q, w_hold_cnt_d;
    logic             r_revoked_q,  w_revoked_d;

    logic [WIDTH-1:0] w_pick_req;
    logic [IDX_W-1:0] w_pick_idx;
    logic [WIDTH-1:0] w_pick_onehot;
    logic             w_any_req;
    logic             w_release;
    logic             w_timeout;
    logic             w_end;

    // The owner's own bit is excluded so a back-to-back handoff never
    // re-selects the releasing requester. In IDLE r_gnt_q is zero, so this
    // is the plain request vector there.
    assign w_pick_req = bus.req & ~r_gnt_q;

    rr_pick #(
        .WIDTH_LOG (WIDTH_LOG)
    ) u_pick (
        .i_req      (w_pick_req),
        .i_last_idx (r_last_idx_q),
        .o_pick_idx (w_pick_idx),
        .o_any_req  (w_any_req)
    );

    assign w_pick_onehot = WIDTH'(1) << w_pick_idx[WIDTH_LOG-1:0];

    // Release beats timeout; both only matter while in GRANT.
    assign w_release = bus.done || ((bus.req & r_gnt_q) == '0);
    assign w_timeout = (MAX_HOLD != 0) && (r_hold_cnt_q == c_hold_last);
    assign w_end     = w_release || w_timeout;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q    <= IDLE;
            r_gnt_q      <= '0;
            r_gnt_idx_q  <= '0;
            r_last_idx_q <= '0;
            r_hold_cnt_q <= '0;
            r_revoked_q  <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_gnt_q      <= w_gnt_d;
            r_gnt_idx_q  <= w_gnt_idx_d;
            r_last_idx_q <= w_last_idx_d;
            r_hold_cnt_q <= w_hold_cnt_d;
            r_revoked_q  <= w_revoked_d;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            IDLE: begin
                if (w_any_req) w_state_d = GRANT;
            end
            GRANT: begin
                if (w_end) w_state_d = (c_b2b_en && w_any_req) ? GRANT : IDLE;
            end
            default: w_state_d = IDLE;
        endcase
    end

    // Grant / counter datapath.
    always_comb begin
        w_gnt_d      = r_gnt_q;
        w_gnt_idx_d  = r_gnt_idx_q;
        w_last_idx_d = r_last_idx_q;
        w_hold_cnt_d = r_hold_cnt_q;
        w_revoked_d  = 1'b0;
        case (r_state_q)
            IDLE: begin
                if (w_any_req) begin
                    w_gnt_d      = w_pick_onehot;
                    w_gnt_idx_d  = w_pick_idx;
                    w_last_idx_d = w_pick_idx;
                    w_hold_cnt_d = '0;
                end
            end
            GRANT: begin
                if (w_end) begin
                    w_revoked_d  = w_timeout && !w_release;
                    w_gnt_d      = '0;
                    w_gnt_idx_d  = '0;
                    w_hold_cnt_d = '0;
                    if (c_b2b_en && w_any_req) begin
                        w_gnt_d      = w_pick_onehot;
                        w_gnt_idx_d  = w_pick_idx;
                        w_last_idx_d = w_pick_idx;
                    end
                end else if (r_hold_cnt_q != '1) begin
                    w_hold_cnt_d = r_hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                w_gnt_d     = '0;
                w_gnt_idx_d = '0;
            end
        endcase
    end

    assign bus.gnt       = r_gnt_q;
    assign bus.gnt_valid = |r_gnt_q;
    assign bus.gnt_idx   = r_gnt_idx_q;
    assign bus.revoked   = r_revoked_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter.sv
// ============================================================================
//  Module      : tb_rr_arbiter
//  Description : Scoreboard bench for rr_arbiter. Two DUTs share stimulus:
//                dut0 with MAX_HOLD=0, dut1 with MAX_HOLD=4. A rotation-based
//                reference model predicts every cycle's outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arbiter;
    import rr_arbiter_pkg::*;

    localparam int WL = 2;
    localparam int W  = 1 << WL;

`ifdef RR_ARBITER_B2B_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] gnt;
        logic         valid;
        logic [7:0]   idx;
        logic         rev;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] req = '0;
    logic         done = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rr_arbiter_if #(.WIDTH_LOG(WL)) bus0 ();
    rr_arbiter_if #(.WIDTH_LOG(WL)) bus1 ();

    assign bus0.req  = req;
    assign bus0.done = done;
    assign bus1.req  = req;
    assign bus1.done = done;

    rr_arbiter #(.WIDTH_LOG(WL), .MAX_HOLD(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    rr_arbiter #(.WIDTH_LOG(WL), .MAX_HOLD(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    // ---------------- reference model ----------------
    int  m_owner[2];
    int  m_last[2];
    int  m_held[2];
    bit  m_rev[2];
    exp_t q0[$];
    exp_t q1[$];

    // Scan downward from the previous winner, wrapping through the top.
    function automatic int model_pick(input logic [W-1:0] r, input int last);
        for (int k = 1; k <= W; k++) begin
            int c;
            c = (last - k + W) % W;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_step(input int d, input int mh);
        int p;
        if (!rst_n) begin
            m_owner[d] = -1; m_last[d] = 0; m_held[d] = 0; m_rev[d] = 1'b0;
        end else if (m_owner[d] < 0) begin
            m_rev[d] = 1'b0;
            p = model_pick(req, m_last[d]);
            if (p >= 0) begin
                m_owner[d] = p; m_last[d] = p; m_held[d] = 1;
            end
        end else begin
            bit rel, to;
            rel = done || !req[m_owner[d]];
            to  = !rel && (mh != 0) && (m_held[d] == mh);
            if (rel || to) begin
                logic [W-1:0] r2;
                int old;
                m_rev[d] = to;
                old = m_owner[d];
                m_owner[d] = -1;
                m_held[d] = 0;
                if (B2B) begin
                    r2 = req;
                    r2[old] = 1'b0;
                    p = model_pick(r2, old);
                    if (p >= 0) begin
                        m_owner[d] = p; m_last[d] = p; m_held[d] = 1;
                    end
                end
            end else begin
                m_held[d] = m_held[d] + 1;
                m_rev[d] = 1'b0;
            end
        end
    endtask

    function automatic exp_t model_out(input int d);
        exp_t e;
        e.valid = (m_owner[d] >= 0);
        e.gnt   = e.valid ? W'(1 << m_owner[d]) : '0;
        e.idx   = e.valid ? 8'(m_owner[d]) : 8'd0;
        e.rev   = m_rev[d];
        return e;
    endfunction

    always @(posedge clk) begin
        model_step(0, 0);
        model_step(1, 4);
        q0.push_back(model_out(0));
        q1.push_back(model_out(1));
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    bit       cap_en = 1'b0;
    int       order[$];
    logic     prev_valid = 1'b0;
    logic [7:0] prev_idx = '0;

    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("d0 gnt",       32'(bus0.gnt),       32'(e.gnt));
            chk("d0 gnt_valid", 32'(bus0.gnt_valid), 32'(e.valid));
            chk("d0 gnt_idx",   32'(bus0.gnt_idx),   32'(e.idx));
            chk("d0 revoked",   32'(bus0.revoked),   32'(e.rev));
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("d1 gnt",       32'(bus1.gnt),       32'(e.gnt));
            chk("d1 gnt_valid", 32'(bus1.gnt_valid), 32'(e.valid));
            chk("d1 gnt_idx",   32'(bus1.gnt_idx),   32'(e.idx));
            chk("d1 revoked",   32'(bus1.revoked),   32'(e.rev));
        end
        if (cap_en && bus0.gnt_valid === 1'b1 && (!prev_valid || bus0.gnt_idx != prev_idx))
            order.push_back(int'(bus0.gnt_idx));
        prev_valid = bus0.gnt_valid;
        prev_idx   = bus0.gnt_idx;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; done = 1'b0;
        step(); step();
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_order[6];
        exp_order = '{3, 2, 1, 0, 3, 2};

        do_reset();
        chk("reset valid", 32'(bus0.gnt_valid), 32'd0);

        // Reset priority: highest requester wins with last_idx = 0.
        req = 4'b0101;
        step();
        chk("prio idx", 32'(bus0.gnt_idx), 32'd2);
        repeat (10) step();
        chk("prio hold", 32'(bus0.gnt), 32'b0100);

        // Reset mid-grant drops everything, no revoke pulse.
        rst_n = 1'b0;
        step();
        chk("midrst valid", 32'(bus0.gnt_valid), 32'd0);
        chk("midrst rev",   32'(bus1.revoked),   32'd0);
        rst_n = 1'b1; req = '0;
        step();

        // Rotation with done pulsed on every grant.
        req = 4'b1111;
        cap_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            done = (m_owner[0] >= 0);
            step();
        end
        cap_en = 1'b0; done = 1'b0;
        chk("order len", 32'(order.size() >= 6), 32'd1);
        for (int i = 0; i < 6; i++)
            chk("order", (i < order.size()) ? 32'(order[i]) : 32'hFFFF, 32'(exp_order[i]));

        // Mask fallback: last_idx = 1, req = 1010 -> MSB.
        do_reset();
        req = 4'b0010;
        step();
        done = 1'b1; req = '0;
        step();
        done = 1'b0; req = 4'b1010;
        step();
        chk("fallback idx", 32'(bus0.gnt_idx), 32'd3);

        // Request drop releases without a revoke pulse.
        do_reset();
        req = 4'b0100;
        step();
        req = '0;
        step();
        chk("drop valid", 32'(bus0.gnt_valid), 32'd0);
        chk("drop idx",   32'(bus0.gnt_idx),   32'd0);
        chk("drop rev",   32'(bus0.revoked),   32'd0);

        // Timeout on dut1 (MAX_HOLD = 4).
        do_reset();
        req = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("to held", 32'(bus1.gnt_valid), 32'd1);
        end
        step();
        chk("to valid", 32'(bus1.gnt_valid), 32'd0);
        chk("to rev",   32'(bus1.revoked),   32'd1);
        step();
        chk("to regrant", 32'(bus1.gnt), 32'b0001);
        chk("to rev end", 32'(bus1.revoked), 32'd0);

        // Handoff from owner 3 with 2 still requesting.
        do_reset();
        req = 4'b1100;
        step();
        chk("b2b first", 32'(bus0.gnt), 32'b1000);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("b2b next", 32'(bus0.gnt), B2B ? 32'b0100 : 32'b0000);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 3) == 0) req = W'($urandom);
            done = ($urandom_range(0, 3) == 0);
            step();
        end
        rst_n = 1'b1; req = '0; done = 1'b0;
        step(); step();
        chk("q0 drained", 32'(q0.size()), 32'd0);
        chk("q1 drained", 32'(q1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Round-robin arbiter sharing one resource (e.g. a sieve/divider unit) between 2^WIDTH_LOG requesters.
- Priority is MSB-first, with the pointer rotating downward from the last winner, so the grant index matches the 8-bit MSB-index format used by the encoders.
- A grant is held until the owner releases it, drops its request, or exceeds a hold timeout.
- Sits between requesting engines and the shared unit; gnt_idx drives the unit's input mux.

Parameters:
- WIDTH_LOG, 2, log2 of the number of requesters; WIDTH = 1 << WIDTH_LOG, max 128.
- MAX_HOLD, 0, max cycles a grant may be held before forced revoke; 0 disables the timeout.

Ports:
- clk  input  1  clock; all state updates on posedge
- rst_n  input  1  synchronous active-low reset
- req  input  WIDTH  request vector; requester i holds req[i] high until served
- done  input  1  single-cycle release pulse from the current owner
- gnt  output  WIDTH  one-hot grant, registered; all zero when no grant
- gnt_valid  output  1  high while a grant is held; equals |gnt
- gnt_idx  output  8  binary index of the owner, zero-extended; 0 when gnt_valid=0
- revoked  output  1  one-cycle pulse when a grant is removed by timeout

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - gnt=0, gnt_valid=0, gnt_idx=0, revoked=0.
  - last_idx=0, hold_cnt=0, state=IDLE.
  - Reset mid-grant drops the grant on the same edge; no revoked pulse.
- Selection (combinational):
  - mask = bits strictly below last_idx.
  - If req & mask is nonzero, pick the MSB index of (req & mask); otherwise pick the MSB index of req.
  - With last_idx=0 the mask is empty, so the highest requester wins.
- FSM states:
  - IDLE: if req != 0, load gnt/gnt_idx from the pick, set last_idx = pick and hold_cnt=0, go to GRANT. gnt_valid rises the cycle after req is first seen (1-cycle latency). If req == 0, stay in IDLE.
  - GRANT, release: if done=1 or req[gnt_idx]=0, clear the grant and go to IDLE (base build). Release takes priority over timeout in the same cycle.
  - GRANT, timeout: else if MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1, clear the grant, pulse revoked for one cycle, and go to IDLE.
  - GRANT, otherwise: hold_cnt += 1 (saturating width clog2(MAX_HOLD)+1) and hold the grant.
- Base build: at least one idle cycle (gnt_valid=0) between consecutive grants.
- done while in IDLE is ignored.
- New requests during GRANT do not preempt the owner.
- A revoked requester that keeps req high rejoins arbitration normally; it has lowest rotation priority because it equals last_idx.
- Wrap-around: with last_idx=0 and the owner released, the next pick is the MSB of req.

Optional Feature:
- Macro: RR_ARBITER_B2B_EN.
- Defined: on release or timeout, if (req with the old owner's bit cleared) is nonzero, load the next pick on the same edge and stay in GRANT. The pick uses last_idx = old owner. gnt_valid stays 1 and there is no bubble. revoked still pulses on timeout.
- Undefined: the base behaviour above, with a mandatory IDLE cycle.

Decomposition:
- Package rr_arbiter_pkg:
  - FSM state enum {IDLE, GRANT}.
  - IDX_W = 8 for the index width.
  - Function to compute the hold-counter width from MAX_HOLD.
- One natural sub-module, rr_pick (combinational):
  - Inputs: req, last_idx.
  - Outputs: pick index (8 bits) and any_req.
  - Internally two MSB encoders (masked and unmasked) plus a 2:1 select.
- The FSM, counter and grant registers stay in rr_arbiter.

Test Plan:
- Reset priority: WIDTH_LOG=2, reset, req=4'b0101 -> one cycle later gnt=4'b0100, gnt_idx=2. Hold done=0 for 10 cycles -> grant unchanged.
- Rotation: req=4'b1111 held, done pulsed each grant -> grant order 3,1?? no; expected order 3,2,1,0,3,2, with exactly one idle cycle between grants (base build).
- Wrap/mask fallback: last_idx=1, req=4'b1010 -> gnt_idx=3 (nothing below 1 is requesting, so MSB of all).
- Request drop: owner 2 deasserts req[2] while done=0 -> next cycle gnt_valid=0, gnt_idx=0, revoked=0.
- Timeout: MAX_HOLD=4, req=4'b0001 held, no done -> gnt_valid high for exactly 4 cycles, then revoked=1 for one cycle. Regrant to 0 follows after one idle cycle.
- Back-to-back (RR_ARBITER_B2B_EN defined): req=4'b1100, done pulsed at owner 3 -> gnt switches 4'b1000 -> 4'b0100 on the same edge with no gnt_valid gap. Also check reset asserted mid-grant -> all outputs 0 on the next edge.
